// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer loader.
// Holds the state encoding, frame sizing and the gamma curve.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_ACK
    } state_t;

    localparam int WORD_W = 24;
    localparam int UP_HI  = 23;
    localparam int UP_LO  = 12;
    localparam int LO_HI  = 11;
    localparam int LO_LO  = 0;

    localparam int DEF_WORDS  = 96 * 48 / 2;
    localparam int DEF_ADDR_W = $clog2(DEF_WORDS);

    // Entry i lives at bits [4i+3:4i]
    localparam logic [63:0] GAMMA = {
        4'd15, 4'd13, 4'd11, 4'd9, 4'd7, 4'd6, 4'd5, 4'd4,
        4'd3,  4'd2,  4'd2,  4'd1, 4'd1, 4'd0, 4'd0, 4'd0
    };

    function automatic int words(int w, int h);
        return w * h / 2;
    endfunction

    function automatic logic [WORD_W-1:0] gamma24(logic [WORD_W-1:0] d);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = GAMMA[4*d[4*i +: 4] +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/framebuffer_loader_byte_packer.sv
// Byte-phase counter and MSB-first assembly of three bytes into a word.
// clear loads the current byte as byte 0 of a fresh word.
module byte_packer
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift,
    input  logic [7:0]        data,
    output logic              done,
    output logic [WORD_W-1:0] word
);

    logic [1:0]  phase;
    logic [15:0] acc;

    assign done = shift && phase == 2'd2;
    assign word = {acc, data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 2'd0;
            acc   <= '0;
        end else if (clear) begin
            phase <= 2'd1;
            acc   <= {8'h00, data};
        end else if (shift) begin
            phase <= done ? 2'd0 : phase + 2'd1;
            acc   <= {acc[7:0], data};
        end
    end

endmodule

// File: rtl/framebuffer_loader.sv
// Byte stream to framebuffer RAM writer with frame-ack hold-off.
// Define FB_LOADER_GAMMA_EN for a registered per-channel gamma stage.
module framebuffer_loader
    import fb_pkg::*;
#(
    parameter int WIDTH  = 96,
    parameter int HEIGHT = 48,
    parameter int BPP    = 12,
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_byte,
    input  logic              i_valid,
    input  logic              i_sof,
    output logic              o_ready,
    output logic [ADDR_W-1:0] addr_a,
    output logic [2*BPP-1:0]  data_in_a,
    output logic              wr_en,
    output logic              o_frame_done,
    input  logic              i_frame_ack,
    output logic              o_resync
);

    localparam int WORDS = words(WIDTH, HEIGHT);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              acc;
    logic              start;
    logic              shift;
    logic              done;
    logic [WORD_W-1:0] word;

    assign acc   = i_valid && o_ready;
    assign start = acc && i_sof;
    assign shift = acc && !i_sof && state == LOAD;

    byte_packer u_packer (
        .clk   (i_clk),
        .rst   (i_rst),
        .clear (start),
        .shift (shift),
        .data  (i_byte),
        .done  (done),
        .word  (word)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            addr     <= '0;
            o_ready  <= 1'b1;
            o_resync <= 1'b0;
        end else begin
            o_resync <= start && state == LOAD;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        addr  <= '0;
                    end
                end
                LOAD: begin
                    if (start) begin
                        addr <= '0;
                    end else if (done) begin
                        if (addr == LAST) begin
                            state   <= WAIT_ACK;
                            o_ready <= 1'b0;
                            addr    <= '0;
                        end else begin
                            addr <= addr + ADDR_W'(1);
                        end
                    end
                end
                WAIT_ACK: begin
                    if (i_frame_ack) begin
                        state   <= IDLE;
                        o_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FB_LOADER_GAMMA_EN
    logic              st_en;
    logic              st_last;
    logic [ADDR_W-1:0] st_addr;
    logic [WORD_W-1:0] st_raw;
    logic [WORD_W-1:0] st_data;

    // Raw word staged one cycle; the table lookup feeds the output register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_en   <= 1'b0;
            st_last <= 1'b0;
            st_addr <= '0;
            st_raw  <= '0;
        end else begin
            st_en   <= done;
            st_last <= done && addr == LAST;
            if (done) begin
                st_addr <= addr;
                st_raw  <= word;
            end
        end
    end

    assign st_data = gamma24(st_raw);
`else
    logic              st_en;
    logic              st_last;
    logic [ADDR_W-1:0] st_addr;
    logic [WORD_W-1:0] st_data;

    assign st_en   = done;
    assign st_last = addr == LAST;
    assign st_addr = addr;
    assign st_data = word;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_en        <= 1'b0;
            o_frame_done <= 1'b0;
            addr_a       <= '0;
            data_in_a    <= '0;
        end else begin
            wr_en        <= st_en;
            o_frame_done <= st_en && st_last;
            if (st_en) begin
                addr_a    <= st_addr;
                data_in_a <= st_data;
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_loader.sv
// Directed bench for framebuffer_loader with a frame-position reference model.
// Honours FB_LOADER_GAMMA_EN for write latency and data mapping.
module tb_framebuffer_loader;

    localparam int WORDS = 96 * 48 / 2;
`ifdef FB_LOADER_GAMMA_EN
    localparam int LAT = 2;
    int gtab [16] = '{0, 0, 0, 1, 1, 2, 2, 3, 4, 5, 6, 7, 9, 11, 13, 15};
`else
    localparam int LAT = 1;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_byte = 8'h00;
    logic        i_valid = 1'b0;
    logic        i_sof = 1'b0;
    logic        i_frame_ack = 1'b0;
    logic        o_ready;
    logic [11:0] addr_a;
    logic [23:0] data_in_a;
    logic        wr_en;
    logic        o_frame_done;
    logic        o_resync;

    framebuffer_loader dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_byte       (i_byte),
        .i_valid      (i_valid),
        .i_sof        (i_sof),
        .o_ready      (o_ready),
        .addr_a       (addr_a),
        .data_in_a    (data_in_a),
        .wr_en        (wr_en),
        .o_frame_done (o_frame_done),
        .i_frame_ack  (i_frame_ack),
        .o_resync     (o_resync)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [23:0] fix(logic [23:0] d);
`ifdef FB_LOADER_GAMMA_EN
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) r[4*i +: 4] = 4'(gtab[d[4*i +: 4]]);
        return r;
`else
        return d;
`endif
    endfunction

    // Reference: byte position in frame; word k = bytes 3k..3k+2
    int          pos = -1;
    bit          waiting = 1'b0;
    logic [23:0] mw = '0;
    bit          dl_en [LAT];
    bit          dl_last [LAT];
    int          dl_addr [LAT];
    logic [23:0] dl_data [LAT];
    bit          n_en, n_last;
    int          n_addr;
    logic [23:0] n_data;
    bit          e_ready = 1'b1, e_wr = 1'b0, e_fd = 1'b0, e_rs = 1'b0;
    int          e_addr = 0;
    logic [23:0] e_data = '0;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pos = -1;
            waiting = 1'b0;
            for (int i = 0; i < LAT; i++) begin
                dl_en[i] = 1'b0;
                dl_last[i] = 1'b0;
                dl_addr[i] = 0;
                dl_data[i] = '0;
            end
            e_ready = 1'b1; e_wr = 1'b0; e_fd = 1'b0; e_rs = 1'b0;
            e_addr = 0; e_data = '0;
        end else begin
            n_en = 1'b0; n_last = 1'b0; n_addr = 0; n_data = '0;
            e_rs = 1'b0;
            if (!waiting && i_valid) begin
                if (i_sof) begin
                    e_rs = pos >= 0;
                    pos = 0;
                end
                if (pos >= 0) begin
                    mw[23 - 8 * (pos % 3) -: 8] = i_byte;
                    if (pos % 3 == 2) begin
                        n_en = 1'b1;
                        n_addr = pos / 3;
                        n_data = fix(mw);
                        n_last = pos / 3 == WORDS - 1;
                    end
                    if (n_last) begin
                        pos = -1;
                        waiting = 1'b1;
                    end else begin
                        pos++;
                    end
                end
            end else if (waiting && i_frame_ack) begin
                waiting = 1'b0;
            end
            for (int i = LAT - 1; i > 0; i--) begin
                dl_en[i] = dl_en[i-1];
                dl_last[i] = dl_last[i-1];
                dl_addr[i] = dl_addr[i-1];
                dl_data[i] = dl_data[i-1];
            end
            dl_en[0] = n_en; dl_last[0] = n_last;
            dl_addr[0] = n_addr; dl_data[0] = n_data;
            e_wr = dl_en[LAT-1];
            e_fd = dl_en[LAT-1] && dl_last[LAT-1];
            if (e_wr) begin
                e_addr = dl_addr[LAT-1];
                e_data = dl_data[LAT-1];
            end
            e_ready = !waiting;
        end
    end

    int          total = 0;
    int          bad = 0;
    int          nwr = 0;
    int          nrs = 0;
    int          nfd = 0;
    int          fd_addr = -1;
    int          wa [$];
    logic [23:0] wd [$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("ready", 32'(o_ready), 32'(e_ready));
        chk("wr_en", 32'(wr_en), 32'(e_wr));
        chk("frame_done", 32'(o_frame_done), 32'(e_fd));
        chk("resync", 32'(o_resync), 32'(e_rs));
        chk("addr_a", 32'(addr_a), 32'(e_addr));
        chk("data_in_a", 32'(data_in_a), 32'(e_data));
        if (wr_en === 1'b1) begin
            nwr++;
            wa.push_back(int'(addr_a));
            wd.push_back(data_in_a);
        end
        if (o_resync === 1'b1) nrs++;
        if (o_frame_done === 1'b1) begin
            nfd++;
            fd_addr = int'(addr_a);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
        compare_model();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(logic [7:0] b, logic s);
        i_valid = 1'b1;
        i_byte = b;
        i_sof = s;
        step();
    endtask

    task automatic idle(int n);
        i_valid = 1'b0;
        i_sof = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    logic [7:0] pat [3] = '{8'h00, 8'h0F, 8'hFF};
    int n0, r0, f0;

    initial begin
        step();
        step();
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        i_rst = 1'b0;
        idle(2);

        n0 = nwr;
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b0);
        idle(3);
        chk("stray_writes", 32'(nwr - n0), 32'd0);
        chk("stray_addr", 32'(addr_a), 32'd0);

        n0 = nwr; f0 = nfd;
        send(8'hF0, 1'b1);
        for (int k = 1; k < 3 * WORDS; k++) send(pat[k % 3], 1'b0);
        idle(3);
        chk("frame_writes", 32'(nwr - n0), 32'(WORDS));
        chk("frame_first_addr", 32'(wa[n0]), 32'd0);
        chk("frame_first_data", 32'(wd[n0]), 32'hF00FFF);
        chk("frame_last_addr", 32'(wa[nwr-1]), 32'd2303);
        chk("frame_done_cnt", 32'(nfd - f0), 32'd1);
        chk("frame_done_addr", 32'(fd_addr), 32'd2303);
        chk("frame_ready_low", 32'(o_ready), 32'd0);

        n0 = nwr;
        i_valid = 1'b1; i_sof = 1'b1; i_byte = 8'h55;
        for (int i = 0; i < 10; i++) step();
        chk("hold_writes", 32'(nwr - n0), 32'd0);
        chk("hold_ready", 32'(o_ready), 32'd0);
        i_valid = 1'b0; i_sof = 1'b0;
        i_frame_ack = 1'b1;
        step();
        i_frame_ack = 1'b0;
        chk("ack_ready", 32'(o_ready), 32'd1);
        idle(2);

        n0 = nwr; r0 = nrs;
        send(8'hA0, 1'b1);
        for (int i = 1; i < 5; i++) send(8'hA0 + 8'(i), 1'b0);
        send(8'hB0, 1'b1);
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        idle(3);
        chk("abort_writes", 32'(nwr - n0), 32'd2);
        chk("abort_resync", 32'(nrs - r0), 32'd1);
        chk("abort_addr0", 32'(wa[n0]), 32'd0);
        chk("abort_addr1", 32'(wa[n0+1]), 32'd0);

        send(8'h01, 1'b1);
        for (int k = 1; k < 302; k++) send(8'(k), 1'b0);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_ready", 32'(o_ready), 32'd1);
        chk("arst_wr_en", 32'(wr_en), 32'd0);
        chk("arst_addr", 32'(addr_a), 32'd0);
        chk("arst_data", 32'(data_in_a), 32'd0);
        chk("arst_done", 32'(o_frame_done), 32'd0);
        chk("arst_resync", 32'(o_resync), 32'd0);
        i_valid = 1'b0; i_sof = 1'b0;
        step();
        step();
        i_rst = 1'b0;
        idle(2);

        n0 = nwr;
        send(8'h8F, 1'b1);
        send(8'h70, 1'b0);
        send(8'h30, 1'b0);
        idle(3);
        chk("post_rst_writes", 32'(nwr - n0), 32'd1);
        chk("post_rst_addr", 32'(wa[n0]), 32'd0);
`ifdef FB_LOADER_GAMMA_EN
        chk("gamma_data", 32'(wd[n0]), 32'h4F3010);
`else
        chk("plain_data", 32'(wd[n0]), 32'h8F7030);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
